// File: rtl/freq_gate_if.sv
// freq_gate_if: result handshake between freq_gate_counter and its readout.
//
//   count_out    [COUNT_BITS] edges counted in the last completed gate window
//   count_valid  result pending; held high until acknowledged
//   count_ack    consumer acknowledge
//   overflow     the latched window saturated its counter
//   overrun      sticky: a pending result was replaced before it was acked
//   measuring    a gate window is in progress
//
// Handshake: the producer raises count_valid together with a new count_out
// and holds both stable until it sees count_ack high on a clock edge while
// count_valid is high; count_valid then drops on the following cycle.
// count_ack while count_valid is low has no effect. If a new result lands
// while count_valid is still high and unacked, it replaces the old one and
// overrun is set. An ack on the very cycle a new result lands is consumed by
// that result, so count_valid stays high and overrun is not set.
interface freq_gate_if #(
  parameter int COUNT_BITS = 16
) ();
  logic [COUNT_BITS-1:0] count_out;
  logic                  count_valid;
  logic                  count_ack;
  logic                  overflow;
  logic                  overrun;
  logic                  measuring;

  modport master (
    output count_out, count_valid, overflow, overrun, measuring,
    input  count_ack
  );

  modport slave (
    input  count_out, count_valid, overflow, overrun, measuring,
    output count_ack
  );
endinterface

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: measures an asynchronous square wave by counting its
// rising edges over back-to-back gate windows of GATE_CYCLES clocks and
// presenting each count on a valid/ack interface.
//
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   freq_in    asynchronous square wave to measure
//   enable     level; high keeps gate windows running back to back
//   res        result interface (master side, see freq_gate_if)
//   state_dbg  current FSM state (0 = idle, 1 = measure)
module freq_gate_counter #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int GATE_CYCLES = CLOCK_FREQ / 1000,
  parameter int COUNT_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freq_in,
  input  logic        enable,
  freq_gate_if.master res,
  output logic [0:0]  state_dbg
);

  localparam int                    GW         = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]         GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] COUNT_MAX  = '1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  logic                  sync1, sync2, hist;
  logic                  edge_pulse;
  logic [0:0]            state;
  logic [GW-1:0]         gate_cnt;
  logic [COUNT_BITS-1:0] edge_cnt;
  logic                  sat;

  logic                  at_max;
  logic [COUNT_BITS-1:0] edge_next;
  logic                  sat_next;
  logic                  terminal;

  // Two-flop synchronizer plus a history flop; runs regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= freq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // edge_next/sat_next are what this cycle's edge does to the window count;
  // the terminal cycle latches them directly so its own edge is not lost.
  always_comb begin
    edge_pulse = sync2 & ~hist;
    at_max     = (edge_cnt == COUNT_MAX);
    edge_next  = edge_cnt;
    if (edge_pulse && !at_max) begin
      edge_next = edge_cnt + COUNT_BITS'(1);
    end
    sat_next   = sat | (edge_pulse & at_max);
    terminal   = (state == ST_MEASURE) && (gate_cnt == GATE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (enable) begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (terminal || !enable) begin
            // Window closes (terminal) or is abandoned (enable dropped);
            // either way the next window starts from zero.
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            if (!enable) begin
              state <= ST_IDLE;
            end
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_next;
            sat      <= sat_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result registers. A latch takes priority over an ack on the same cycle,
  // so a simultaneous ack is absorbed by the fresh result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.count_out   <= '0;
      res.count_valid <= 1'b0;
      res.overflow    <= 1'b0;
      res.overrun     <= 1'b0;
    end else if (terminal) begin
      res.count_out   <= edge_next;
      res.overflow    <= sat_next;
      res.count_valid <= 1'b1;
      if (res.count_valid && !res.count_ack) begin
        res.overrun <= 1'b1;
      end
    end else if (res.count_valid && res.count_ack) begin
      res.count_valid <= 1'b0;
    end
  end

  assign res.measuring = (state == ST_MEASURE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_freq_gate_counter.sv
module tb_freq_gate_counter;
  localparam int G = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fa = 1'b0, fb = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [0:0] st_a, st_b;

  freq_gate_if #(.COUNT_BITS(16)) if_a ();
  freq_gate_if #(.COUNT_BITS(4))  if_b ();

  freq_gate_counter #(.CLOCK_FREQ(50_000_000), .GATE_CYCLES(G), .COUNT_BITS(16)) u_a (
    .clk(clk), .rst_n(rst_n), .freq_in(fa), .enable(en_a), .res(if_a), .state_dbg(st_a)
  );

  freq_gate_counter #(.CLOCK_FREQ(50_000_000), .GATE_CYCLES(G), .COUNT_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .freq_in(fb), .enable(en_b), .res(if_b), .state_dbg(st_b)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  // After posedge number k, cyc == k (sampled at the following negedge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- stimulus generators ----------------
  // Half periods in clock cycles; 0 freezes the wave. rnd_a picks a fresh
  // random half period (1..30 cycles) after every toggle of fa.
  int half_a = 0, half_b = 0;
  bit rnd_a = 1'b0;
  int ph_a = 0, ph_b = 0, rh_a = 1;

  always @(negedge clk) begin : gen_blk
    int ha;
    ha = rnd_a ? rh_a : half_a;
    if (ha > 0) begin
      if (ph_a + 1 >= ha) begin
        fa = ~fa; ph_a = 0; rh_a = $urandom_range(1, 30);
      end else ph_a++;
    end
    if (half_b > 0) begin
      if (ph_b + 1 >= half_b) begin
        fb = ~fb; ph_b = 0;
      end else ph_b++;
    end
  end

  // ---------------- reference model ----------------
  // Every rising edge of the input is logged as the index of the first clock
  // edge that sees it high (only while out of reset). Such an edge reaches
  // the window count two clocks later, so a window entered at clock e counts
  // the edges first seen at clocks e-1 .. e+G-2.
  int  edge_a[$], edge_b[$];
  logic prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a <= 1'b0; prev_b <= 1'b0;
    end else begin
      if (fa && !prev_a) edge_a.push_back(cyc + 1);
      if (fb && !prev_b) edge_b.push_back(cyc + 1);
      prev_a <= fa; prev_b <= fb;
    end
  end

  function automatic int model_cnt(input bit sel, input int e);
    int n = 0;
    if (sel) begin
      foreach (edge_b[i]) if (edge_b[i] >= e - 1 && edge_b[i] <= e + G - 2) n++;
    end else begin
      foreach (edge_a[i]) if (edge_a[i] >= e - 1 && edge_a[i] <= e + G - 2) n++;
    end
    return n;
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  int last_a = 0;  // value count_out of instance a should currently hold

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; half_a = 7; half_b = 3;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) if_a.count_ack = 1'b1;   // ack with nothing pending: ignored
      repeat (500) @(negedge clk);
      if_a.count_ack = 1'b0;
      n_checks++;
      if ({if_a.count_out, if_a.count_valid, if_a.overflow, if_a.overrun, if_a.measuring,
           if_b.count_out, if_b.count_valid, if_b.overflow, if_b.overrun, if_b.measuring} !== '0) begin
        n_errors++;
        $display("FAIL reset_idle[%0d]: a out=%0d v=%b of=%b or=%b m=%b b out=%0d v=%b m=%b, want all 0",
                 i, if_a.count_out, if_a.count_valid, if_a.overflow, if_a.overrun, if_a.measuring,
                 if_b.count_out, if_b.count_valid, if_b.measuring);
      end
    end
    half_a = 0; half_b = 0;
  endtask

  task automatic test_nominal();
    int e, exp;
    half_a = 25;
    repeat ($urandom_range(3, 40)) @(negedge clk);
    en_a = 1'b1; e = cyc + 1;
    for (int w = 0; w < 6; w++) begin
      if (w == 3) half_a = 5;
      wait_cyc(e + G * (w + 1) - 1);
      n_checks++;
      if (if_a.count_valid !== 1'b0 || if_a.measuring !== 1'b1) begin
        n_errors++;
        $display("FAIL nominal_pre[%0d]: valid=%b measuring=%b, want 0/1", w, if_a.count_valid, if_a.measuring);
      end
      wait_cyc(e + G * (w + 1));
      exp = model_cnt(0, e + G * w);
      last_a = exp;
      n_checks++;
      if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp) || if_a.overflow !== 1'b0) begin
        n_errors++;
        $display("FAIL nominal[%0d]: valid=%b out=%0d of=%b, want 1/%0d/0", w, if_a.count_valid,
                 if_a.count_out, if_a.overflow, exp);
      end
      if_a.count_ack = 1'b1;
      @(negedge clk);
      if_a.count_ack = 1'b0;
      n_checks++;
      if (if_a.count_valid !== 1'b0 || if_a.count_out !== 16'(exp)) begin
        n_errors++;
        $display("FAIL nominal_ack[%0d]: valid=%b out=%0d, want 0/%0d", w, if_a.count_valid, if_a.count_out, exp);
      end
    end
    en_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_a.measuring !== 1'b0 || if_a.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL nominal_stop: measuring=%b overrun=%b, want 0/0", if_a.measuring, if_a.overrun);
    end
    half_a = 0;
  endtask

  task automatic test_saturation();
    int e, n, exp;
    half_b = 5;
    repeat (30) @(negedge clk);
    en_b = 1'b1; e = cyc + 1;
    for (int w = 0; w < 3; w++) begin
      if (w == 1) half_b = 250;
      wait_cyc(e + G * (w + 1));
      n = model_cnt(1, e + G * w);
      exp = (n > 15) ? 15 : n;
      n_checks++;
      if (if_b.count_valid !== 1'b1 || if_b.count_out !== 4'(exp) || if_b.overflow !== (n > 15)) begin
        n_errors++;
        $display("FAIL saturation[%0d]: valid=%b out=%0d of=%b, want 1/%0d/%0d (raw %0d)", w,
                 if_b.count_valid, if_b.count_out, if_b.overflow, exp, n > 15, n);
      end
      if_b.count_ack = 1'b1;
      @(negedge clk);
      if_b.count_ack = 1'b0;
    end
    en_b = 1'b0; half_b = 0;
  endtask

  task automatic test_overrun();
    int e, exp1, exp2;
    half_a = 25;
    repeat ($urandom_range(3, 40)) @(negedge clk);
    en_a = 1'b1; e = cyc + 1;
    wait_cyc(e + G);
    exp1 = model_cnt(0, e);
    n_checks++;
    if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp1) || if_a.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_first: valid=%b out=%0d or=%b, want 1/%0d/0", if_a.count_valid,
               if_a.count_out, if_a.overrun, exp1);
    end
    wait_cyc(e + 2 * G);
    exp2 = model_cnt(0, e + G);
    last_a = exp2;
    n_checks++;
    if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp2) || if_a.overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_second: valid=%b out=%0d or=%b, want 1/%0d/1", if_a.count_valid,
               if_a.count_out, if_a.overrun, exp2);
    end
    if_a.count_ack = 1'b1; en_a = 1'b0;
    @(negedge clk);
    if_a.count_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (if_a.count_valid !== 1'b0 || if_a.count_out !== 16'(exp2) || if_a.overrun !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_sticky: valid=%b out=%0d or=%b, want 0/%0d/1", if_a.count_valid,
               if_a.count_out, if_a.overrun, exp2);
    end
    half_a = 0;
  endtask

  task automatic test_ack_on_terminal();
    int e, exp;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    half_a = 5;
    repeat ($urandom_range(3, 40)) @(negedge clk);
    en_a = 1'b1; e = cyc + 1;
    wait_cyc(e + 2 * G - 1);
    if_a.count_ack = 1'b1;         // high exactly across the second terminal edge
    @(negedge clk);
    if_a.count_ack = 1'b0;
    exp = model_cnt(0, e + G);
    last_a = exp;
    n_checks++;
    if (if_a.count_valid !== 1'b1 || if_a.overrun !== 1'b0 || if_a.count_out !== 16'(exp)) begin
      n_errors++;
      $display("FAIL ack_on_terminal: valid=%b or=%b out=%0d, want 1/0/%0d", if_a.count_valid,
               if_a.overrun, if_a.count_out, exp);
    end
    if_a.count_ack = 1'b1; en_a = 1'b0;
    @(negedge clk);
    if_a.count_ack = 1'b0;
    half_a = 0;
  endtask

  task automatic test_abort();
    int e, e2, exp;
    half_a = 25;
    repeat (10) @(negedge clk);
    en_a = 1'b1; e = cyc + 1;
    wait_cyc(e + 500);
    en_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_a.measuring !== 1'b0 || if_a.count_valid !== 1'b0 || if_a.count_out !== 16'(last_a)) begin
      n_errors++;
      $display("FAIL abort: measuring=%b valid=%b out=%0d, want 0/0/%0d", if_a.measuring,
               if_a.count_valid, if_a.count_out, last_a);
    end
    wait_cyc(e + G + 20);
    n_checks++;
    if (if_a.count_valid !== 1'b0 || if_a.count_out !== 16'(last_a)) begin
      n_errors++;
      $display("FAIL abort_no_result: valid=%b out=%0d, want 0/%0d", if_a.count_valid, if_a.count_out, last_a);
    end
    en_a = 1'b1; e2 = cyc + 1;
    wait_cyc(e2 + G - 1);
    n_checks++;
    if (if_a.count_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_reenable_early: valid=%b, want 0", if_a.count_valid);
    end
    wait_cyc(e2 + G);
    exp = model_cnt(0, e2);
    last_a = exp;
    n_checks++;
    if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp)) begin
      n_errors++;
      $display("FAIL abort_reenable: valid=%b out=%0d, want 1/%0d", if_a.count_valid, if_a.count_out, exp);
    end
    if_a.count_ack = 1'b1; en_a = 1'b0;
    @(negedge clk);
    if_a.count_ack = 1'b0;
    half_a = 0;
  endtask

  task automatic test_async_reset();
    int e, e2, exp;
    half_a = 5;
    en_a = 1'b1; e = cyc + 1;
    wait_cyc(e + G);               // leave a result pending so reset has something to clear
    wait_cyc(e + G + 700);
    @(posedge clk);
    #1;
    rst_n = 1'b0; en_a = 1'b0;
    #1;
    n_checks++;
    if ({if_a.count_out, if_a.count_valid, if_a.overflow, if_a.overrun, if_a.measuring, st_a} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: out=%0d v=%b of=%b or=%b m=%b st=%0d, want all 0", if_a.count_out,
               if_a.count_valid, if_a.overflow, if_a.overrun, if_a.measuring, st_a);
    end
    #2;
    rst_n = 1'b1;
    wait_cyc(e + 2 * G + 10);
    n_checks++;
    if (if_a.count_valid !== 1'b0 || if_a.measuring !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_no_result: valid=%b measuring=%b, want 0/0", if_a.count_valid, if_a.measuring);
    end
    en_a = 1'b1; e2 = cyc + 1;
    wait_cyc(e2 + G);
    exp = model_cnt(0, e2);
    n_checks++;
    if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp) || if_a.overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_restart: valid=%b out=%0d or=%b, want 1/%0d/0", if_a.count_valid,
               if_a.count_out, if_a.overrun, exp);
    end
    if_a.count_ack = 1'b1; en_a = 1'b0;
    @(negedge clk);
    if_a.count_ack = 1'b0;
    half_a = 0;
  endtask

  task automatic test_random();
    int  e, exp;
    bit  pending = 1'b0, exp_or = 1'b0;
    rnd_a = 1'b1;
    repeat ($urandom_range(5, 60)) @(negedge clk);
    en_a = 1'b1; e = cyc + 1;
    for (int w = 0; w < 6; w++) begin
      wait_cyc(e + G * (w + 1));
      if (pending) exp_or = 1'b1;
      exp = model_cnt(0, e + G * w);
      n_checks++;
      if (if_a.count_valid !== 1'b1 || if_a.count_out !== 16'(exp) || if_a.overrun !== exp_or ||
          if_a.overflow !== 1'b0) begin
        n_errors++;
        $display("FAIL random[%0d]: valid=%b out=%0d or=%b of=%b, want 1/%0d/%0d/0", w, if_a.count_valid,
                 if_a.count_out, if_a.overrun, if_a.overflow, exp, exp_or);
      end
      pending = ($urandom_range(0, 1) == 0);
      if (!pending) begin
        repeat ($urandom_range(0, 200)) @(negedge clk);
        if_a.count_ack = 1'b1;
        @(negedge clk);
        if_a.count_ack = 1'b0;
      end
    end
    en_a = 1'b0; rnd_a = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    if_a.count_ack = 1'b0;
    if_b.count_ack = 1'b0;
    test_reset();
    test_nominal();
    test_saturation();
    test_overrun();
    test_ack_on_terminal();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
